// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one 16-bit ALU among 8 requesters.
// Arbitrates in IDLE, issues to the ALU, waits for completion, returns the result.
module alu_rr_scheduler #(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] opa,
    input  logic [N*W-1:0] opb,
    input  logic [4*N-1:0] opc,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [3:0]     alu_op,
    output logic           alu_go,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_done,
    output logic [W-1:0]   y,
    output logic [N-1:0]   done,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t       state;
    logic [2:0]   ptr;
    logic [2:0]   tag;
    logic [2:0]   winner;
    logic [2:0]   idx;
    logic         found;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [3:0]   sel_op;

    // Scan upward from ptr; the 3-bit add wraps naturally modulo 8.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int k = 0; k < N; k++) begin
            if (winner == 3'(k)) begin
                sel_a  = opa[k*W +: W];
                sel_b  = opb[k*W +: W];
                sel_op = opc[k*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            tag    <= '0;
            gnt    <= '0;
            done   <= '0;
            alu_go <= 1'b0;
            busy   <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                        tag    <= winner;
                        gnt    <= {{(N-1){1'b0}}, 1'b1} << winner;
                        alu_go <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt    <= '0;
                    alu_go <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        y     <= alu_y;
                        done  <= {{(N-1){1'b0}}, 1'b1} << tag;
                        state <= RETURN;
                    end
                end
                RETURN: begin
                    // The winner moves to the back of the priority order.
                    done  <= '0;
                    ptr   <= tag + 3'd1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: responder ALU plus a round-robin reference model.
module tb_alu_rr_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   req;
    logic [127:0] opa;
    logic [127:0] opb;
    logic [31:0]  opc;
    logic [7:0]   gnt;
    logic [15:0]  alu_a;
    logic [15:0]  alu_b;
    logic [3:0]   alu_op;
    logic         alu_go;
    logic [15:0]  alu_y;
    logic         alu_done;
    logic [15:0]  y;
    logic [7:0]   done;
    logic         busy;

    int         checks = 0;
    int         passes = 0;
    int         aluLatency = 1;
    int         aluCnt = 0;
    bit         aluAuto = 1'b1;
    logic [2:0] ptrModel = 3'd0;

    alu_rr_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb), .opc(opc),
        .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_go(alu_go),
        .alu_y(alu_y), .alu_done(alu_done), .y(y), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] aluRef(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        return op[0] ? (a ^ b) : (a + b);
    endfunction

    function automatic int pickWinner(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++)
            if (r[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    function automatic logic [15:0] sliceA(input int k);
        return opa[k*16 +: 16];
    endfunction

    function automatic logic [15:0] sliceB(input int k);
        return opb[k*16 +: 16];
    endfunction

    function automatic logic [3:0] sliceOp(input int k);
        return opc[k*4 +: 4];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic randomizeOps;
        opa = {$urandom, $urandom, $urandom, $urandom};
        opb = {$urandom, $urandom, $urandom, $urandom};
        opc = $urandom;
    endtask

    // Simple ALU: raises alu_done aluLatency cycles after it sees alu_go.
    initial begin
        alu_done = 1'b0;
        alu_y    = '0;
        forever begin
            tick();
            if (aluAuto) begin
                alu_done = 1'b0;
                if (aluCnt > 0) begin
                    aluCnt--;
                    if (aluCnt == 0) begin
                        alu_done = 1'b1;
                        alu_y    = aluRef(alu_a, alu_b, alu_op);
                    end
                end
                if (alu_go) aluCnt = aluLatency;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        opa = '0;
        opb = '0;
        opc = '0;
        tick();
        checks++; if (busy !== 1'b0 || gnt !== 8'h00 || done !== 8'h00 || alu_go !== 1'b0)
            $display("[TB] FAIL reset_ctrl: busy=%b gnt=%h done=%h go=%b expected all 0", busy, gnt, done, alu_go);
        else passes++;
        rst = 1'b0;
        // Complete one op on requester 5 so ptr and y are non-zero before reset.
        opa[5*16 +: 16] = 16'hA5A5;
        opb[5*16 +: 16] = 16'h0101;
        opc[5*4 +: 4]   = 4'h0;
        opa[0 +: 16]    = 16'h5A5A;
        opb[0 +: 16]    = 16'h1111;
        opc[0 +: 4]     = 4'h1;
        req = 8'h20;
        tick();
        req = 8'h00;
        repeat (3) tick();
        checks++; if (y !== 16'hA6A6)
            $display("[TB] FAIL pre_reset_y: got %h expected %h", y, 16'hA6A6);
        else passes++;
        req = 8'h01;
        tick();
        req = 8'h00;
        #3;
        rst = 1'b1;
        aluCnt = 0;
        #1;
        checks++; if (gnt !== 8'h00 || alu_go !== 1'b0 || busy !== 1'b0 || done !== 8'h00)
            $display("[TB] FAIL async_reset_ctrl: gnt=%h go=%b busy=%b done=%h expected 0", gnt, alu_go, busy, done);
        else passes++;
        checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_op !== 4'h0 || y !== 16'h0)
            $display("[TB] FAIL async_reset_data: a=%h b=%h op=%h y=%h expected 0", alu_a, alu_b, alu_op, y);
        else passes++;
        tick();
        rst = 1'b0;
        ptrModel = 3'd0;
    endtask

    // Drives a sequence of operations and checks every grant and completion
    // against the round-robin model.
    task automatic test_arbitration(input bit randomMode, input int nOps);
        int         w;
        int         cyc;
        bit         gotDone;
        logic [7:0] expOh;
        logic [15:0] expY;
        logic [15:0] expA;
        logic [15:0] expB;
        logic [3:0]  expOp;
        for (int n = 0; n < nOps; n++) begin
            req = randomMode ? 8'($urandom & $urandom) : 8'hFF;
            aluLatency = randomMode ? int'($urandom_range(1, 4)) : 1;
            randomizeOps();
            w = pickWinner(req, int'(ptrModel));
            if (w < 0) begin
                tick();
                checks++; if (gnt !== 8'h00 || busy !== 1'b0)
                    $display("[TB] FAIL idle_no_req: gnt=%h busy=%b expected 00/0", gnt, busy);
                else passes++;
                continue;
            end
            expOh = 8'b1 << w;
            expA  = sliceA(w);
            expB  = sliceB(w);
            expOp = sliceOp(w);
            expY  = aluRef(expA, expB, expOp);
            tick();
            checks++; if (gnt !== expOh || alu_go !== 1'b1 || busy !== 1'b1)
                $display("[TB] FAIL grant op%0d: gnt=%h go=%b busy=%b expected %h/1/1", n, gnt, alu_go, busy, expOh);
            else passes++;
            checks++; if (alu_a !== expA || alu_b !== expB || alu_op !== expOp)
                $display("[TB] FAIL operands op%0d: %h %h %h expected %h %h %h", n, alu_a, alu_b, alu_op, expA, expB, expOp);
            else passes++;
            if (randomMode) randomizeOps();
            cyc = 0;
            gotDone = 1'b0;
            while (cyc < 20 && !gotDone) begin
                tick();
                cyc++;
                if (cyc == 1) begin
                    checks++; if (gnt !== 8'h00 || alu_go !== 1'b0)
                        $display("[TB] FAIL grant_pulse op%0d: gnt=%h go=%b expected 00/0", n, gnt, alu_go);
                    else passes++;
                end
                if (done !== 8'h00) gotDone = 1'b1;
            end
            checks++; if (!gotDone || done !== expOh || y !== expY || cyc != aluLatency + 1)
                $display("[TB] FAIL done op%0d: done=%h y=%h cyc=%0d expected %h %h %0d", n, done, y, cyc, expOh, expY, aluLatency + 1);
            else passes++;
            tick();
            checks++; if (done !== 8'h00 || busy !== 1'b0)
                $display("[TB] FAIL return_end op%0d: done=%h busy=%b expected 00/0", n, done, busy);
            else passes++;
            ptrModel = 3'(w + 1);
        end
        req = '0;
    endtask

    task automatic test_round_robin;
        test_arbitration(1'b0, 10);
    endtask

    task automatic test_random;
        test_arbitration(1'b1, 30);
    endtask

    task automatic test_single;
        int cyc;
        aluLatency = 1;
        randomizeOps();
        opa[3*16 +: 16] = 16'h1234;
        opb[3*16 +: 16] = 16'h0011;
        opc[3*4 +: 4]   = 4'h2;
        req = 8'h08;
        tick();
        req = 8'h00;
        checks++; if (gnt !== 8'h08 || alu_a !== 16'h1234 || alu_op !== 4'h2)
            $display("[TB] FAIL single_issue: gnt=%h a=%h op=%h expected 08 1234 2", gnt, alu_a, alu_op);
        else passes++;
        cyc = 0;
        while (cyc < 10 && done === 8'h00) begin
            tick();
            cyc++;
        end
        checks++; if (done !== 8'h08 || y !== 16'h1245 || cyc != 2)
            $display("[TB] FAIL single_done: done=%h y=%h cyc=%0d expected 08 1245 2", done, y, cyc);
        else passes++;
        tick();
        ptrModel = 3'd4;
    endtask

    task automatic test_stall;
        int          k;
        int          cyc;
        int          doneCount;
        bit          stable;
        logic [15:0] expA;
        logic [15:0] expB;
        logic [3:0]  expOp;
        aluLatency = 5;
        randomizeOps();
        k = int'($urandom_range(0, 7));
        expA  = sliceA(k);
        expB  = sliceB(k);
        expOp = sliceOp(k);
        req = 8'b1 << k;
        tick();
        req = 8'h00;
        checks++; if (gnt !== (8'b1 << k))
            $display("[TB] FAIL stall_grant: gnt=%h expected %h", gnt, 8'b1 << k);
        else passes++;
        stable = 1'b1;
        doneCount = 0;
        cyc = 0;
        while (cyc < 6) begin
            tick();
            cyc++;
            if (cyc == 2) randomizeOps();
            if (busy !== 1'b1 || alu_a !== expA || alu_b !== expB || alu_op !== expOp) stable = 1'b0;
            if (done !== 8'h00) doneCount++;
        end
        checks++; if (!stable)
            $display("[TB] FAIL stall_hold: busy=%b a=%h b=%h op=%h expected 1 %h %h %h", busy, alu_a, alu_b, alu_op, expA, expB, expOp);
        else passes++;
        checks++; if (y !== aluRef(expA, expB, expOp))
            $display("[TB] FAIL stall_y: got %h expected %h", y, aluRef(expA, expB, expOp));
        else passes++;
        repeat (4) begin
            tick();
            if (done !== 8'h00) doneCount++;
        end
        checks++; if (doneCount != 1)
            $display("[TB] FAIL stall_done_count: got %0d expected 1", doneCount);
        else passes++;
        ptrModel = 3'(k + 1);
        aluLatency = 1;
    endtask

    task automatic test_reset_wait;
        bit sawDone;
        aluLatency = 30;
        randomizeOps();
        req = 8'($urandom_range(1, 255));
        tick();
        req = 8'h00;
        repeat (2) tick();
        #3;
        rst = 1'b1;
        aluCnt = 0;
        #1;
        checks++; if (busy !== 1'b0 || y !== 16'h0 || done !== 8'h00)
            $display("[TB] FAIL reset_wait: busy=%b y=%h done=%h expected 0 0000 00", busy, y, done);
        else passes++;
        tick();
        rst = 1'b0;
        aluLatency = 1;
        sawDone = 1'b0;
        repeat (3) begin
            tick();
            if (done !== 8'h00) sawDone = 1'b1;
        end
        checks++; if (sawDone)
            $display("[TB] FAIL reset_wait_no_done: done pulse seen, expected none");
        else passes++;
        randomizeOps();
        req = 8'h01;
        tick();
        req = 8'h00;
        checks++; if (gnt !== 8'h01)
            $display("[TB] FAIL reset_wait_regrant: gnt=%h expected 01", gnt);
        else passes++;
        repeat (3) tick();
        ptrModel = 3'd1;
    endtask

    task automatic test_spurious;
        int          k;
        logic [15:0] yPrev;
        logic [15:0] expY;
        aluAuto = 1'b0;
        alu_done = 1'b1;
        alu_y = 16'hBEEF;
        req = 8'h00;
        yPrev = y;
        repeat (2) tick();
        checks++; if (y !== yPrev || done !== 8'h00)
            $display("[TB] FAIL spurious_idle: y=%h done=%h expected %h 00", y, done, yPrev);
        else passes++;
        k = int'($urandom_range(0, 7));
        randomizeOps();
        expY = aluRef(sliceA(k), sliceB(k), sliceOp(k));
        req = 8'b1 << k;
        tick();
        req = 8'h00;
        checks++; if (gnt !== (8'b1 << k))
            $display("[TB] FAIL spurious_grant: gnt=%h expected %h", gnt, 8'b1 << k);
        else passes++;
        tick();
        alu_done = 1'b0;
        checks++; if (y !== yPrev || done !== 8'h00 || busy !== 1'b1)
            $display("[TB] FAIL spurious_issue: y=%h done=%h busy=%b expected %h 00 1", y, done, busy, yPrev);
        else passes++;
        repeat (2) tick();
        checks++; if (done !== 8'h00 || y !== yPrev)
            $display("[TB] FAIL spurious_wait: done=%h y=%h expected 00 %h", done, y, yPrev);
        else passes++;
        alu_done = 1'b1;
        alu_y = expY;
        tick();
        alu_done = 1'b0;
        checks++; if (done !== (8'b1 << k) || y !== expY)
            $display("[TB] FAIL spurious_done: done=%h y=%h expected %h %h", done, y, 8'b1 << k, expY);
        else passes++;
        tick();
        checks++; if (done !== 8'h00 || busy !== 1'b0)
            $display("[TB] FAIL spurious_end: done=%h busy=%b expected 00 0", done, busy);
        else passes++;
        ptrModel = 3'(k + 1);
        aluCnt = 0;
        aluAuto = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_reset_wait();
        test_spurious();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
